readbuf_engine: RTL and testbench
=================================

# readbuf_engine

Read-side controller for the 8-line packet buffer, sitting directly downstream of `write_wrapper`. It watches the write side's committed line index, drives the buffer read port, and replays each complete line as an AXI-Stream-style frame through a 4-entry output FIFO. It returns `greenflag` to the write side so writing stalls only when all free lines are exhausted.

## Interface
- `DATA_W`, 8, width of buffer read data and `o_tdata`
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `wr_ptr_tribit`  in  3  write side's next-line-to-write index; lines strictly before it are complete
- `rd_ptr`  out  13  buffer read address {line[2:0], word[9:0]}
- `rd_ptr_tribit`  out  3  line currently being read
- `rden`  out  1  buffer read enable; data returns next cycle
- `rd_data`  in  DATA_W  buffer read data, valid cycle after `rden`
- `rd_data_last`  in  1  end-of-line flag stored with word, valid cycle after `rden`
- `o_tvalid`  out  1  output beat valid
- `o_tdata`  out  DATA_W  output beat data
- `o_tlast`  out  1  last beat of frame
- `o_tready`  in  1  downstream accept
- `greenflag`  out  1  write side may begin/continue a new line

## Operation
- Reset values: `rd_ptr`=0, `rd_ptr_tribit`=0, `rden`=0, `o_tvalid`=0, `o_tdata`=0, `o_tlast`=0, `greenflag`=1, FSM=IDLE, FIFO empty, in-flight flag clear.
- FSM IDLE: line available when `rd_ptr_tribit != wr_ptr_tribit`; then go READ, word index=0.
- FSM READ: `rden` asserted (combinationally) when `fifo_count + inflight < 4`; each issued read increments word index.
- Returned word pushed into FIFO with its last flag. Word index 1023 returned without `rd_data_last` is forced last (`o_tlast`=1).
- On returning last word: any read issued in that same cycle (overrun past end of line) is squashed (data discarded, not pushed); `rd_ptr_tribit` increments mod 8; word index=0; FSM→IDLE.
- IDLE always occupies ≥1 cycle between lines; no read issued in IDLE.
- FIFO pops when `o_tvalid && o_tready`; simultaneous push and pop keeps count unchanged.
- `greenflag` registered: next value `(wr_ptr_tribit + 3'd1) != rd_ptr_tribit`. Max 7 lines occupied; equal pointers mean empty.
- Reset asserted mid-frame: all state cleared immediately; partial frame abandoned, no `o_tlast` emitted.

## Timing
- Line committed (`wr_ptr_tribit` changes) sampled at edge n → READ and first `rden` cycle n+1 → data pushed edge n+2 → `o_tvalid` high cycle n+2 (FIFO head drives outputs from registers).
- Sustained throughput 1 beat/cycle with `o_tready` held high; 1 dead IDLE cycle plus 1 squashed read per line boundary.
- `o_tvalid` once high stays high with stable `o_tdata`/`o_tlast` until accepted.
- `greenflag` lags `rd_ptr_tribit` change by 1 cycle.
- Backpressure: with `o_tready` low, at most 4 words buffered (FIFO + in-flight), `rden` deasserts.

## Configuration
- `RDBUF_FRAMECNT_EN` defined: adds output `frame_cnt` [15:0], reset 0, increments on each accepted beat with `o_tlast`=1, wraps 65535→0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Single 4-word line (last on word 3), `o_tready`=1, `wr_ptr_tribit` 0→1: `rd_ptr` 0,1,2,3,(4 squashed); 4 beats, `o_tlast` only on 4th; `rd_ptr_tribit`→1; no 5th beat.
- Seven lines committed, `o_tready`=0: `greenflag` 0 while `wr_ptr_tribit`=7, `rd_ptr_tribit`=0; after first line drained to FIFO and `rd_ptr_tribit`=1, `greenflag` 1 one cycle later.
- Backpressure: 10-word line, `o_tready` toggled 1/0 each cycle: 10 beats in order, data matches buffer, `rden` never exceeds 4 outstanding.
- Wrap: lines 6,7,0 consecutively: `rd_ptr` upper bits 6→7→0, `rd_ptr_tribit` wraps 7→0, three frames emitted.
- Unterminated line: 1024 words, no last flag: beat 1024 has `o_tlast`=1, `rd_ptr_tribit` advances.
- Reset pulse low mid-frame after 2 of 5 beats: outputs to reset values same cycle; no further beats until new line committed.

Source files
------------

// File: rtl/readbuf_engine_if.sv
// Signal bundle between readbuf_engine, the packet buffer read port, the write side and the stream sink.
// With RDBUF_FRAMECNT_EN defined, the bundle also carries the frame counter.
interface readbuf_engine_if #(
  parameter int DATA_W = 8
);
  logic [2:0]        wr_ptr_tribit;
  logic [12:0]       rd_ptr;
  logic [2:0]        rd_ptr_tribit;
  logic              rden;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_last;
  logic              o_tvalid;
  logic [DATA_W-1:0] o_tdata;
  logic              o_tlast;
  logic              o_tready;
  logic              greenflag;
`ifdef RDBUF_FRAMECNT_EN
  logic [15:0]       frame_cnt;
`endif

  modport master (
    input  wr_ptr_tribit, rd_data, rd_data_last, o_tready,
    output rd_ptr, rd_ptr_tribit, rden, o_tvalid, o_tdata, o_tlast, greenflag
`ifdef RDBUF_FRAMECNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output wr_ptr_tribit, rd_data, rd_data_last, o_tready,
    input  rd_ptr, rd_ptr_tribit, rden, o_tvalid, o_tdata, o_tlast, greenflag
`ifdef RDBUF_FRAMECNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/readbuf_engine.sv
// Read-side controller: replays each committed buffer line as a stream frame through a 4-entry FIFO.
// Optional feature macro RDBUF_FRAMECNT_EN adds a 16-bit count of accepted frames.
module readbuf_engine #(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  readbuf_engine_if.master   bus
);

  typedef enum logic {IDLE, READ} state_t;
  localparam int DEPTH = 4;

  state_t            state;
  logic [2:0]        line;
  logic [9:0]        word_idx;
  logic              inflight;
  logic [9:0]        inflight_idx;
  logic [DATA_W:0]   fifo_mem [DEPTH];
  logic [1:0]        wr_idx;
  logic [1:0]        rd_idx;
  logic [2:0]        count;
  logic              greenflag_q;

  logic              ret_last;
  logic              push;
  logic              pop;
  logic              issue;

  // NOTE: every signal gets a value before any condition so no latch can be inferred.
  always_comb begin
    push     = inflight;
    ret_last = inflight && (bus.rd_data_last || inflight_idx == 10'd1023);
    pop      = (count != 3'd0) && bus.o_tready;
    issue    = (state == READ) && (({1'b0, count} + {3'b000, inflight}) < 4'd4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      line         <= 3'd0;
      word_idx     <= 10'd0;
      inflight     <= 1'b0;
      inflight_idx <= 10'd0;
      wr_idx       <= 2'd0;
      rd_idx       <= 2'd0;
      count        <= 3'd0;
      greenflag_q  <= 1'b1;
      // NOTE: the FIFO storage is reset because its head drives o_tdata directly.
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of its peers.
      greenflag_q <= (bus.wr_ptr_tribit + 3'd1) != line;
      // A read issued while the line's last word returns runs past the line end and is dropped.
      inflight    <= issue && !ret_last;
      if (issue) inflight_idx <= word_idx;

      if (push) begin
        fifo_mem[wr_idx] <= {ret_last, bus.rd_data};
        wr_idx           <= wr_idx + 2'd1;
      end
      if (pop) rd_idx <= rd_idx + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (!push && pop) count <= count - 3'd1;

      case (state)
        IDLE: begin
          if (line != bus.wr_ptr_tribit) begin
            state    <= READ;
            word_idx <= 10'd0;
          end
        end
        READ: begin
          if (ret_last) begin
            state    <= IDLE;
            line     <= line + 3'd1;
            word_idx <= 10'd0;
          end else if (issue) begin
            word_idx <= word_idx + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rden          = issue;
  assign bus.rd_ptr        = {line, word_idx};
  assign bus.rd_ptr_tribit = line;
  assign bus.greenflag     = greenflag_q;
  assign bus.o_tvalid      = (count != 3'd0);
  assign bus.o_tdata       = fifo_mem[rd_idx][DATA_W-1:0];
  assign bus.o_tlast       = (count != 3'd0) && fifo_mem[rd_idx][DATA_W];

`ifdef RDBUF_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      frame_cnt_q <= 16'd0;
    else if (pop && bus.o_tlast)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_readbuf_engine.sv
// Self-checking bench for readbuf_engine: a behavioural buffer plus a frame-level scoreboard.
module tb_readbuf_engine;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  readbuf_engine_if #(.DATA_W(DATA_W)) bus ();
  readbuf_engine #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int beat_cnt = 0;
  int rden_cnt = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random

  logic [DATA_W:0]  buf_mem [8192];  // {last, data}
  logic [DATA_W:0]  exp_q [$];
  logic [12:0]      addr_q [$];
  logic             hold_pend = 1'b0;
  logic [DATA_W:0]  hold_val;

  // Buffer read port: data and last flag return the cycle after rden.
  always @(posedge clk) begin
    if (bus.rden) {bus.rd_data_last, bus.rd_data} <= buf_mem[bus.rd_ptr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: read addresses, beat scoreboard and stall stability.
  always @(negedge clk) begin
    if (rst && bus.rden) begin
      addr_q.push_back(bus.rd_ptr);
      rden_cnt++;
    end
    if (rst && hold_pend) begin
      check("hold_valid", bus.o_tvalid, 1);
      check("hold_beat", {bus.o_tlast, bus.o_tdata}, hold_val);
    end
    if (rst && bus.o_tvalid && bus.o_tready) begin
      beat_cnt++;
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("beat", {bus.o_tlast, bus.o_tdata}, exp_q.pop_front());
    end
    hold_pend = rst && bus.o_tvalid && !bus.o_tready;
    hold_val  = {bus.o_tlast, bus.o_tdata};
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.o_tready = 1'b0;
      1:       bus.o_tready = 1'b1;
      2:       bus.o_tready = ~bus.o_tready;
      default: bus.o_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Fill a line; words past the end carry a last flag so a wrongly kept overrun read shows up.
  task automatic write_line(input int line, input int len, input bit terminated);
    for (int w = 0; w < 1024; w++) begin
      logic [DATA_W-1:0] d;
      logic l;
      d = DATA_W'($urandom);
      if (w < len) l = terminated && (w == len - 1);
      else         l = 1'b1;
      buf_mem[line * 1024 + w] = {l, d};
    end
  endtask

  // Reference frame: words from 0 up to the first last flag, or word 1023 forced last.
  task automatic expect_line(input int line);
    for (int w = 0; w < 1024; w++) begin
      logic [DATA_W:0] e;
      logic stop;
      e = buf_mem[line * 1024 + w];
      stop = e[DATA_W] || (w == 1023);
      exp_q.push_back({stop, e[DATA_W-1:0]});
      if (stop) break;
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < max_cycles) begin
      step();
      cyc++;
    end
    repeat (6) step();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tvalid"}, bus.o_tvalid, 0);
    check({tag, "_tdata"}, bus.o_tdata, 0);
    check({tag, "_tlast"}, bus.o_tlast, 0);
    check({tag, "_rden"}, bus.rden, 0);
    check({tag, "_rd_ptr"}, bus.rd_ptr, 0);
    check({tag, "_rd_line"}, bus.rd_ptr_tribit, 0);
    check({tag, "_green"}, bus.greenflag, 1);
  endtask

  initial begin
    int seen [$];
    int exp_lines [3];
    int b0;
    int cyc;

    bus.wr_ptr_tribit = 3'd0;
    bus.o_tready = 1'b0;
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b1;
    ready_mode = 1;
    repeat (2) step();

    // Single 4-word line: timing, addresses including the dropped overrun read.
    write_line(0, 4, 1'b1);
    expect_line(0);
    addr_q.delete();
    rden_cnt = 0;
    bus.wr_ptr_tribit = 3'd1;
    step();
    check("t1_first_rden", bus.rden, 1);
    check("t1_first_addr", bus.rd_ptr, 0);
    check("t1_tvalid_n", bus.o_tvalid, 0);
    step();
    check("t1_tvalid_n1", bus.o_tvalid, 0);
    step();
    check("t1_tvalid_n2", bus.o_tvalid, 1);
    drain("t1_drain", 40);
    check("t1_rden_cnt", rden_cnt, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t1_addr%0d", i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF, i);
    check("t1_rd_line", bus.rd_ptr_tribit, 1);
    check("t1_green", bus.greenflag, 1);

    // Backpressure: stalled sink holds at most 4 words, then toggled ready drains 10 beats.
    write_line(1, 10, 1'b1);
    expect_line(1);
    ready_mode = 0;
    rden_cnt = 0;
    bus.wr_ptr_tribit = 3'd2;
    repeat (12) step();
    check("t2_stall_rden", rden_cnt, 4);
    check("t2_stall_valid", bus.o_tvalid, 1);
    ready_mode = 2;
    drain("t2_drain", 100);
    check("t2_rd_line", bus.rd_ptr_tribit, 2);

    // Random-length lines under random backpressure.
    for (int l = 2; l < 6; l++) begin
      write_line(l, $urandom_range(1, 12), 1'b1);
      expect_line(l);
    end
    ready_mode = 3;
    bus.wr_ptr_tribit = 3'd6;
    drain("t3_drain", 400);
    check("t3_rd_line", bus.rd_ptr_tribit, 6);

    // Wrap: lines 6, 7, 0 back to back.
    write_line(6, $urandom_range(1, 6), 1'b1);
    write_line(7, $urandom_range(1, 6), 1'b1);
    write_line(0, $urandom_range(1, 6), 1'b1);
    expect_line(6);
    expect_line(7);
    expect_line(0);
    addr_q.delete();
    ready_mode = 1;
    bus.wr_ptr_tribit = 3'd1;
    drain("t4_drain", 100);
    foreach (addr_q[i]) begin
      int ln;
      ln = int'(addr_q[i][12:10]);
      if (seen.size() == 0 || seen[$] != ln) seen.push_back(ln);
    end
    exp_lines = '{6, 7, 0};
    check("t4_line_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t4_line%0d", i), (i < seen.size()) ? seen[i] : 32'hFFFF, exp_lines[i]);
    check("t4_rd_line", bus.rd_ptr_tribit, 1);

    // Seven lines committed with sink stalled: greenflag behaviour.
    rst = 1'b0;
    exp_q.delete();
    bus.wr_ptr_tribit = 3'd0;
    repeat (2) step();
    rst = 1'b1;
    step();
    for (int l = 0; l < 7; l++) begin
      write_line(l, 2, 1'b1);
      expect_line(l);
    end
    ready_mode = 0;
    bus.wr_ptr_tribit = 3'd7;
    step();
    check("t5_green_full", bus.greenflag, 0);
    check("t5_rd_line0", bus.rd_ptr_tribit, 0);
    cyc = 0;
    while (bus.rd_ptr_tribit != 3'd1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("t5_reach_line1", bus.rd_ptr_tribit, 1);
    check("t5_green_lag", bus.greenflag, 0);
    step();
    check("t5_green_free", bus.greenflag, 1);
    repeat (10) step();
    check("t5_stall_line", bus.rd_ptr_tribit, 2);
    ready_mode = 3;
    drain("t5_drain", 200);
    check("t5_rd_line", bus.rd_ptr_tribit, 7);
    check("t5_green_end", bus.greenflag, 1);

    // Unterminated 1024-word line: last word forced last.
    write_line(7, 1024, 1'b0);
    expect_line(7);
    ready_mode = 1;
    bus.wr_ptr_tribit = 3'd0;
    drain("t6_drain", 1200);
    check("t6_rd_line", bus.rd_ptr_tribit, 0);

    // Reset mid-frame after 2 of 5 beats.
    write_line(0, 5, 1'b1);
    expect_line(0);
    b0 = beat_cnt;
    bus.wr_ptr_tribit = 3'd1;
    cyc = 0;
    while (beat_cnt - b0 < 2 && cyc < 20) begin
      step();
      cyc++;
    end
    check("t7_two_beats", beat_cnt - b0, 2);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_reset_state("t7_reset");
    bus.wr_ptr_tribit = 3'd0;
    repeat (2) step();
    rst = 1'b1;
    repeat (10) step();
    check("t7_no_beats", beat_cnt - b0, 2);
    check("t7_idle_valid", bus.o_tvalid, 0);
    write_line(0, 3, 1'b1);
    expect_line(0);
    bus.wr_ptr_tribit = 3'd1;
    drain("t7_drain", 40);
`ifdef RDBUF_FRAMECNT_EN
    check("t7_frame_cnt", bus.frame_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
